// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block, read-only instruction cache.
// Hits answer in the same cycle; a miss runs one blocking fill from the memory controller.
module icache_direct #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        dbg_fill
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [31:0]       data [SETS];
  logic [29:0]       miss_word;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              fill_done;
  logic              unused_bits;

  assign req_idx   = imemaddr[IDX_W+1:2];
  assign req_tag   = imemaddr[31:IDX_W+2];
  assign fill_idx  = miss_word[IDX_W-1:0];
  assign fill_tag  = miss_word[29:IDX_W];
  assign unused_bits = ^imemaddr[1:0];

  assign hit       = imemREN && (state == IDLE) && valid[req_idx] && (tags[req_idx] == req_tag);
  assign fill_done = (state == FILL) && !iwait;

  assign ihit     = hit;
  assign imemload = hit ? data[req_idx] : 32'h0;
  assign dbg_fill = (state == FILL);

  // Handshake to the controller: iREN holds high for the whole fill with iaddr stable;
  // iload is taken on the first edge where iREN=1 and iwait=0, then iREN drops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_word <= '0;
      iREN      <= 1'b0;
      iaddr     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit) begin
            miss_word <= imemaddr[31:2];
            iREN      <= 1'b1;
            iaddr     <= {imemaddr[31:2], 2'b00};
            state     <= FILL;
          end
        end
        FILL: begin
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            iREN            <= 1'b0;
            iaddr           <= 32'h0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid vector alone decides whether a frame is usable.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios followed by random traffic, every cycle
// compared against a model that tracks which word address each frame holds.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic        dbg_fill;

  icache_direct #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .dbg_fill(dbg_fill)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: each frame remembers the word address it holds.
  bit          m_vld  [16];
  logic [29:0] m_word [16];
  logic [31:0] m_dat  [16];
  bit          m_fill;
  logic [29:0] m_miss;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_vld[i] = 0;
    m_fill = 0;
    m_miss = '0;
  endtask

  function automatic int frame_of(input logic [29:0] w);
    return int'(w % 30'd16);
  endfunction

  task automatic check_outputs();
    logic [29:0] w;
    bit          eh;
    int          f;
    w  = imemaddr[31:2];
    f  = frame_of(w);
    eh = nRST && imemREN && !m_fill && m_vld[f] && (m_word[f] == w);
    if (eh) exp_q.push_back(m_dat[f]);
    chk("ihit", {31'h0, ihit}, {31'h0, eh});
    chk("imemload", imemload, eh ? exp_q.pop_front() : 32'h0);
    chk("iREN", {31'h0, iREN}, {31'h0, m_fill});
    chk("iaddr", iaddr, m_fill ? {m_miss, 2'b00} : 32'h0);
    chk("dbg_fill", {31'h0, dbg_fill}, {31'h0, m_fill});
  endtask

  task automatic model_advance();
    logic [29:0] w;
    int          f;
    if (!nRST) begin
      model_reset();
      return;
    end
    w = imemaddr[31:2];
    f = frame_of(w);
    if (m_fill) begin
      if (!iwait) begin
        m_vld[frame_of(m_miss)]  = 1;
        m_word[frame_of(m_miss)] = m_miss;
        m_dat[frame_of(m_miss)]  = iload;
        m_fill = 0;
      end
    end else if (imemREN && !(m_vld[f] && m_word[f] == w)) begin
      m_fill = 1;
      m_miss = w;
    end
  endtask

  // Called at posedge+1: drive inputs, check at negedge, advance model, return at next posedge+1.
  task automatic tick(input logic ren, input logic [31:0] addr, input logic wt, input logic [31:0] ld);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = ld;
    @(negedge CLK);
    check_outputs();
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch_miss(input logic [31:0] addr, input int waits, input logic [31:0] ld);
    tick(1'b1, addr, 1'b1, 32'h0);
    for (int i = 0; i < waits; i++) tick(1'b1, addr, 1'b1, 32'h0);
    tick(1'b1, addr, 1'b0, ld);
  endtask

  initial begin
    model_reset();
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    @(posedge CLK);
    #1;
    // Reset held with a live fetch request.
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h0, 1'b1, 32'h0);
    nRST = 1'b1;

    // Cold miss with three wait cycles, then a same-cycle hit.
    fetch_miss(32'h0000_0000, 3, 32'h3C01_0001);
    tick(1'b1, 32'h0000_0000, 1'b1, 32'h0);
    chk("cold_hit_data", imemload, 32'h3C01_0001);
    tick(1'b1, 32'h0000_0002, 1'b1, 32'h0);
    chk("offset_hit", {31'h0, ihit}, 32'h1);

    // Conflict on frame 0, then the original address refills.
    fetch_miss(32'h0000_0040, 1, 32'hAAAA_0000);
    tick(1'b1, 32'h0000_0040, 1'b1, 32'h0);
    tick(1'b1, 32'h0000_0000, 1'b1, 32'h0);
    chk("conflict_miss_iaddr", iaddr, 32'h0);
    chk("conflict_miss_iren", {31'h0, iREN}, 32'h1);
    tick(1'b1, 32'h0000_0000, 1'b0, 32'h1111_2222);
    tick(1'b1, 32'h0000_0000, 1'b1, 32'h0);
    chk("refill_data", imemload, 32'h1111_2222);

    // Request change and halt while filling.
    tick(1'b1, 32'h0000_0004, 1'b1, 32'h0);
    tick(1'b0, 32'h0000_0008, 1'b1, 32'h0);
    chk("midfill_iaddr", iaddr, 32'h4);
    tick(1'b0, 32'h0000_0008, 1'b1, 32'h0);
    tick(1'b0, 32'h0000_0008, 1'b0, 32'h5555_6666);
    tick(1'b0, 32'h0000_0008, 1'b1, 32'h0);
    tick(1'b1, 32'h0000_0004, 1'b1, 32'h0);
    chk("after_halt_hit", imemload, 32'h5555_6666);
    tick(1'b1, 32'h0000_0008, 1'b1, 32'h0);
    tick(1'b1, 32'h0000_0008, 1'b0, 32'h7777_8888);
    tick(1'b1, 32'h0000_0008, 1'b1, 32'h0);

    // Reset while a fill is stalled.
    tick(1'b1, 32'h0000_0020, 1'b1, 32'h0);
    tick(1'b1, 32'h0000_0020, 1'b1, 32'h0);
    nRST = 1'b0;
    #1;
    chk("async_iren", {31'h0, iREN}, 32'h0);
    chk("async_iaddr", iaddr, 32'h0);
    chk("async_ihit", {31'h0, ihit}, 32'h0);
    model_reset();
    @(posedge CLK);
    #1;
    tick(1'b1, 32'h0000_0000, 1'b0, 32'h0);
    nRST = 1'b1;
    tick(1'b1, 32'h0000_0000, 1'b1, 32'h0);
    tick(1'b1, 32'h0000_0000, 1'b1, 32'h0);
    chk("post_reset_miss", {31'h0, iREN}, 32'h1);
    tick(1'b1, 32'h0000_0000, 1'b0, 32'h0BAD_F00D);

    // Random traffic over a small address pool so hits, conflicts and refills all occur.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 3) == 0 ? 24'h00_0001 : 24'h0, 2'b00, 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 3) == 0) a[6] = 1'b1;
      tick($urandom_range(0, 9) < 8, a, $urandom_range(0, 1) == 1, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
